// File: rtl/shift_add_mult_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Holds the FSM state encoding used by the RTL and the bench,
// plus a helper that sizes the iteration counter.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width able to hold the value 'n' without wrapping.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_adder.sv
// Adder: plain unsigned ripple adder with carry in and carry out.
// Ports:
//   in0, in1 : DATA_WIDTH-bit operands
//   cin      : carry in
//   sum      : DATA_WIDTH-bit sum
//   cout     : carry out
module Adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
);

    always_comb begin
        {cout, sum} = {1'b0, in0} + {1'b0, in1} + {{DATA_WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned multiplier, one partial product per cycle.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   start   : begin a multiply (only honoured in IDLE)
//   in0     : multiplicand, captured on accepted start
//   in1     : multiplier, captured on accepted start
//   busy    : high while RUN or DONE
//   done    : one-cycle pulse, product valid
//   product : 2*DATA_WIDTH-bit result, held until next completion
module shift_add_mult
    import shift_add_mult_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   in0,
    input  logic [DATA_WIDTH-1:0]   in1,
    output logic                    busy,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int CW = cnt_width(DATA_WIDTH);

    state_t                  state, state_nxt;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [2*DATA_WIDTH-1:0] acc_shift;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [CW-1:0]           cnt;
    logic [DATA_WIDTH-1:0]   sum;
    logic                    cout;
    logic [DATA_WIDTH-1:0]   upper;
    logic                    upper_c;
    logic                    last;

    Adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .in0  (acc[2*DATA_WIDTH-1:DATA_WIDTH]),
        .in1  (mcand),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The adder carry becomes the new MSB after the shift, so nothing is lost.
    always_comb begin
        upper_c = 1'b0;
        upper   = acc[2*DATA_WIDTH-1:DATA_WIDTH];
        if (acc[0]) begin
            upper_c = cout;
            upper   = sum;
        end
        acc_shift = {upper_c, upper, acc[DATA_WIDTH-1:1]};
        last      = (cnt == CW'(DATA_WIDTH - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // busy/done are registered copies of the next state's decode, so they
    // line up with the state register exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= in0;
                        acc   <= {{DATA_WIDTH{1'b0}}, in1};
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_shift;
                    cnt <= cnt + CW'(1);
                    if (last) product <= acc_shift;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, operand width in bits; product width is 2*DATA_WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 in0  input  DATA_WIDTH  multiplicand, unsigned; captured on accepted start.
REQ-006 in1  input  DATA_WIDTH  multiplier, unsigned; captured on accepted start.
REQ-007 busy  output  1  high while a multiply is in progress (RUN or DONE).
REQ-008 done  output  1  one-cycle pulse marking product valid.
REQ-009 product  output  2*DATA_WIDTH  unsigned result; held stable until the next accepted start.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 IDLE: start=1 at a rising edge SHALL capture in0/in1, clear the accumulator and iteration counter, and move to RUN; start=0 stays in IDLE.
REQ-012 RUN: each cycle, if the multiplier LSB is 1, the upper accumulator half SHALL be added to the multiplicand via the Adder sub-module with cin=0; otherwise the upper half passes unchanged.
REQ-013 RUN: each cycle, the register {cout, upper half, lower half/multiplier} SHALL shift right by one, so the adder carry is never lost (no overflow possible; result exact mod 2^(2*DATA_WIDTH)).
REQ-014 RUN SHALL last exactly DATA_WIDTH cycles; the counter SHALL be ceil(log2(DATA_WIDTH+1)) bits and never wrap within an operation.
REQ-015 After the DATA_WIDTH-th RUN edge, the state SHALL become DONE; product SHALL load the full accumulator on that same edge.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency: start sampled at edge N -> done=1 and product valid during the cycle following edge N+DATA_WIDTH.
REQ-018 start asserted in RUN or DONE SHALL be ignored (no restart, no capture); in0/in1 changes after capture SHALL not affect the result.
REQ-019 start held high continuously SHALL produce back-to-back operations, each accepted in the IDLE cycle following DONE.
REQ-020 busy SHALL be registered and equal (state != IDLE); done SHALL be registered and equal (state == DONE).
REQ-021 Operand zero (either input) SHALL still take the full DATA_WIDTH cycles and yield product 0.

Reset
REQ-022 rst=1 at a rising edge SHALL force state IDLE, busy=0, done=0, product=0, and clear the accumulator and counter.
REQ-023 rst SHALL take priority over start and over any in-flight operation; a reset mid-RUN aborts without asserting done.
REQ-024 After rst deasserts, the first start SHALL be accepted normally in the next cycle.

Structure
REQ-025 FSM state encodings (IDLE=0, RUN=1, DONE=2, 2 bits) SHALL live in a shared include/package used by RTL and bench.
REQ-026 The adder datapath SHALL be one instance of the existing Adder module (in0, in1, cin, sum, cout) with DATA_WIDTH passed through; no other sub-modules.
REQ-027 Accumulator, multiplicand, and counter SHALL be the only storage besides state, busy, done, and product.

Verification
REQ-028 Reset, then start with in0=0x0D, in1=0x0B -> done high one cycle after edge N+8, product=0x008F.
REQ-029 in0=0xFF, in1=0xFF -> product=0xFE01, with carry from Adder preserved.
REQ-030 in0=0x00, in1=0xA5 -> product=0x0000; done still at N+8; busy high for 9 cycles.
REQ-031 start pulses during RUN with different operands -> ignored; first result unchanged, busy never drops early.
REQ-032 rst asserted at RUN cycle 4 -> next cycle busy=0, done=0, product=0; done never pulses for the aborted operation.
REQ-033 Exhaustive sweep over all 65536 operand pairs with start held high -> every done pulse's product equals in0*in1, spaced 10 cycles apart.
